// File: rtl/cic_comp_fir_dec2.sv
// Decimate-by-2 CIC compensation FIR.
// A circular sample buffer collects every input sample. Every second sample starts
// a TAPS-long multiply-accumulate pass through one shared MAC. The result is rounded
// half-up, saturated, and presented for one strobe cycle.
//
// state | meaning
// IDLE  | waiting for a trigger (odd-numbered sample); coefficient writes allowed
// RUN   | issuing taps k = 0..TAPS-1 into the read/multiply/accumulate pipeline
// DRAIN | pipeline flush (3 cycles); last cycle rounds, saturates and fires out_strobe
module cic_comp_fir_dec2 #(
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 32,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_strobe,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic [COEF_WIDTH-1:0]         coef_data,
  output logic                          out_strobe,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          busy,
  output logic                          overrun
);

  localparam int AW    = $clog2(TAPS);
  localparam int BW    = AW + 1;
  localparam int FW    = AW + 2;
  localparam int PW    = IN_WIDTH + COEF_WIDTH;
  localparam int SHIFT = COEF_WIDTH - 1 - (OUT_WIDTH - IN_WIDTH);

  localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(2 * TAPS);

  localparam logic signed [ACC_WIDTH:0] RND_HALF =
    (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    ((ACC_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - (ACC_WIDTH+1)'(1);
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = -((ACC_WIDTH+1)'(1) << (OUT_WIDTH - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [IN_WIDTH-1:0]   sample_mem [2*TAPS];
  logic signed [COEF_WIDTH-1:0] coef_mem   [TAPS];

  logic [BW-1:0] wptr;
  logic          phase;
  logic [FW-1:0] fill_cnt;
  logic [FW-1:0] fill_inc;

  logic [BW-1:0] newest;
  logic [FW-1:0] fill_snap;
  logic [AW-1:0] tap_k;
  logic [1:0]    drain_cnt;

  logic          trigger;
  logic          start;
  logic          fire;
  logic          coef_wr_ok;
  logic [BW-1:0] rd_addr;
  logic          tap_live;

  logic                         rd_valid;
  logic signed [IN_WIDTH-1:0]   rd_x;
  logic signed [COEF_WIDTH-1:0] rd_c;
  logic                         mul_valid;
  logic signed [PW-1:0]         mul_p;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [ACC_WIDTH:0]    acc_rnd;
  logic signed [ACC_WIDTH:0]    acc_shr;
  logic [OUT_WIDTH-1:0]         out_sat;

  // Trigger and sample-history bookkeeping shared by the FSM and the buffers.
  always_comb begin
    trigger    = in_strobe && phase;
    fill_inc   = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + FW'(1);
    coef_wr_ok = coef_we && (state == IDLE) && !trigger;
    rd_addr    = newest - BW'(tap_k);
    tap_live   = FW'(tap_k) < fill_snap;
  end

  // FSM next state and one-cycle control pulses.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (tap_k == K_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Tap index during RUN and flush countdown during DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      tap_k     <= '0;
      drain_cnt <= '0;
    end else begin
      if (start)               tap_k <= '0;
      else if (state == RUN)   tap_k <= tap_k + AW'(1);
      if (state == RUN && tap_k == K_LAST) drain_cnt <= 2'd2;
      else if (state == DRAIN)             drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Write pointer, decimation phase, fill count and per-run snapshots.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      phase     <= 1'b0;
      fill_cnt  <= '0;
      newest    <= '0;
      fill_snap <= '0;
    end else begin
      if (in_strobe) begin
        wptr     <= wptr + BW'(1);
        phase    <= ~phase;
        fill_cnt <= fill_inc;
      end
      if (start) begin
        newest    <= wptr;
        fill_snap <= fill_inc;
      end
    end
  end

  // Sample buffer: every accepted strobe lands here regardless of FSM state.
  always_ff @(posedge clock) begin
    if (in_strobe && !reset) sample_mem[wptr] <= in_data;
  end

  // Coefficient RAM: host writes only land while the MAC is quiet.
  always_ff @(posedge clock) begin
    if (coef_wr_ok) coef_mem[coef_addr] <= coef_data;
  end

  // Pipeline valid flags for the read and multiply stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      mul_valid <= 1'b0;
    end else begin
      rd_valid  <= (state == RUN);
      mul_valid <= rd_valid;
    end
  end

  // Read and multiply stages; taps beyond the filled history read as zero.
  always_ff @(posedge clock) begin
    rd_x  <= tap_live ? sample_mem[rd_addr] : '0;
    rd_c  <= coef_mem[tap_k];
    mul_p <= rd_x * rd_c;
  end

  // Accumulator: cleared at the trigger, sums full-precision products.
  always_ff @(posedge clock) begin
    if (reset)          acc <= '0;
    else if (start)     acc <= '0;
    else if (mul_valid) acc <= acc + ACC_WIDTH'(mul_p);
  end

  // Round half up, arithmetic shift, then clamp to the output range.
  always_comb begin
    acc_rnd = (ACC_WIDTH+1)'(acc) + RND_HALF;
    acc_shr = acc_rnd >>> SHIFT;
    if (acc_shr > OUT_MAX)      out_sat = OUT_WIDTH'(OUT_MAX);
    else if (acc_shr < OUT_MIN) out_sat = OUT_WIDTH'(OUT_MIN);
    else                        out_sat = OUT_WIDTH'(acc_shr);
  end

  // Output register, strobe and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_strobe <= 1'b0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= fire;
      if (fire) out_data <= out_sat;
      if (trigger && state != IDLE) overrun <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cic_comp_fir_dec2.sv
// Bench for cic_comp_fir_dec2: directed stimulus, expected outputs queued at trigger
// time from a direct-form reference sum, popped by an independent output monitor.
module tb_cic_comp_fir_dec2;

  localparam int IN_WIDTH   = 18;
  localparam int OUT_WIDTH  = 24;
  localparam int COEF_WIDTH = 18;
  localparam int TAPS       = 32;
  localparam int ACC_WIDTH  = 48;
  localparam int SHIFT      = COEF_WIDTH - 1 - (OUT_WIDTH - IN_WIDTH);
  localparam int LAT        = TAPS + 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_strobe = 1'b0;
  logic [IN_WIDTH-1:0]     in_data = '0;
  logic                    coef_we = 1'b0;
  logic [$clog2(TAPS)-1:0] coef_addr = '0;
  logic [COEF_WIDTH-1:0]   coef_data = '0;
  logic                    out_strobe;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    busy;
  logic                    overrun;

  cic_comp_fir_dec2 #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .COEF_WIDTH(COEF_WIDTH),
    .TAPS(TAPS), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clock(clock), .reset(reset),
    .in_strobe(in_strobe), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_strobe(out_strobe), .out_data(out_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int     exp_val_q[$];
  int     exp_cyc_q[$];
  longint hist[$];
  longint m_coef[TAPS];
  bit     m_phase = 1'b0;
  bit     m_overrun = 1'b0;
  int     last_t = -1000;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_out();
    longint sum = 0;
    longint r;
    int n = hist.size();
    int fill = (n > 2*TAPS) ? 2*TAPS : n;
    for (int k = 0; k < TAPS; k++)
      if (k < fill) sum += hist[n-1-k] * m_coef[k];
    r = (sum + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    if (r > 8388607)  r = 8388607;
    if (r < -8388608) r = -8388608;
    return int'(r);
  endfunction

  function automatic bit model_idle();
    return cyc >= last_t + LAT;
  endfunction

  // Present one sample this cycle, then idle until 'gap' cycles after it.
  task automatic send(input longint x, input int gap);
    in_strobe = 1'b1;
    in_data   = IN_WIDTH'(x);
    hist.push_back(x);
    if (m_phase) begin
      if (model_idle()) begin
        exp_val_q.push_back(model_out());
        exp_cyc_q.push_back(cyc + LAT);
        last_t = cyc;
      end else begin
        m_overrun = 1'b1;
      end
    end
    m_phase = !m_phase;
    @(posedge clock); #1;
    in_strobe = 1'b0;
    for (int i = 1; i < gap; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic write_coef(input int k, input longint v);
    coef_we   = 1'b1;
    coef_addr = k[$clog2(TAPS)-1:0];
    coef_data = COEF_WIDTH'(v);
    if (model_idle()) m_coef[k] = v;
    @(posedge clock); #1;
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_val_q.delete();
    exp_cyc_q.delete();
    hist.delete();
    m_phase   = 1'b0;
    m_overrun = 1'b0;
    last_t    = -1000;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3*LAT && exp_val_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    check({name, "_pending"}, exp_val_q.size(), 0);
  endtask

  // Output monitor: every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && out_strobe) begin
      if (exp_val_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        check("out_data", longint'($signed(out_data)), exp_val_q.pop_front());
        check("strobe_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_data", out_data, 0);
    check("rst_out_strobe", out_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clock); #1;

    // Pass-through: coef[0] = 1.0 * 2^16 gives x*32 per odd sample.
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 65536 : 0);
    for (int i = 0; i < 6; i++) send(i, 40);
    wait_drain("passthru");
    check("passthru_overrun", overrun, 0);

    // Coefficient write during RUN is dropped; the same write in IDLE lands.
    send(100, 40);
    send(101, 5);
    check("busy_in_run", busy, 1);
    write_coef(0, 0);
    wait_drain("coefbusy");
    write_coef(0, 0);
    send(102, 40);
    send(103, 40);
    wait_drain("coefidle");

    // Impulse through a ramp of coefficients, starting from a clean history.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * (k + 1));
    send(0, 40);
    send(8192, 40);
    for (int i = 0; i < 34; i++) send(0, 40);
    wait_drain("impulse");

    // Saturation at both rails.
    for (int k = 0; k < TAPS; k++) write_coef(k, 131071);
    for (int i = 0; i < 40; i++) send(131071, 20);
    wait_drain("sat_pos");
    check("sat_pos_hold", longint'($signed(out_data)), 8388607);
    for (int i = 0; i < 40; i++) send(-131072, 20);
    wait_drain("sat_neg");
    check("sat_neg_hold", longint'($signed(out_data)), -8388608);

    // Reset ten cycles into a run aborts it cleanly.
    send(5, 40);
    send(6, 10);
    check("busy_before_reset", busy, 1);
    do_reset();
    @(negedge clock);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    @(posedge clock); #1;
    repeat (LAT + 4) begin
      @(posedge clock); #1;
    end
    for (int i = 1; i <= 6; i++) send(i, 40);
    wait_drain("post_reset");

    // Overrun: second trigger ten cycles after the first is dropped, flag sticks.
    do_reset();
    send(7, 5);
    send(9, 5);
    send(11, 5);
    send(13, 40);
    check("overrun_set", overrun, 1);
    for (int i = 0; i < 6; i++) send(20 + i, 40);
    wait_drain("overrun");
    check("overrun_sticky", overrun, m_overrun);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
